mem_wb_skid_buf: RTL and testbench
==================================

Name: mem_wb_skid_buf

Overview:
- Parametrised successor to the MEM/WB pipeline register. Same payload: WB control, memory data, ALU result, destination register.
- Adds valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered.
- Adds synchronous flush (bubble insertion) and a write-back forwarding tap.
- Sits between the memory stage and the register-file write port.

Parameters:
WB_W, 4, width of WB control field
DATA_W, 32, memory data width
ALU_W, 16, ALU result width; also the forwarding data width (DATA_W >= ALU_W)
REG_W, 3, destination register index width
WREN_BIT, 0, index in WB field of register-write enable
MEM2REG_BIT, 1, index in WB field selecting memory data (1) or ALU result (0) for forwarding
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  clock; all state updates on falling edge of clk
rst  in  1  synchronous active-high reset, sampled on falling edge
enable  in  1  global pipeline enable; 0 freezes all state
flush  in  1  synchronous flush; discards all buffered entries
i_valid  in  1  upstream entry valid
o_ready  out  1  buffer can accept (registered: high iff skid empty)
i_WB  in  WB_W  WB control
i_MemData  in  DATA_W  memory read data
i_alu  in  ALU_W  ALU result
i_Rdst  in  REG_W  destination register
o_valid  out  1  output entry valid
i_ready  in  1  downstream accepts output entry
o_WB  out  WB_W  registered WB control
o_MemData  out  DATA_W  registered memory data
o_alu  out  ALU_W  registered ALU result
o_Rdst  out  REG_W  registered destination
fwd_valid  out  1  o_valid & o_WB[WREN_BIT]
fwd_rdst  out  REG_W  = o_Rdst
fwd_data  out  ALU_W  o_WB[MEM2REG_BIT] ? o_MemData[ALU_W-1:0] : o_alu
stall_cnt  out  CNT_W  optional feature only
bubble_cnt  out  CNT_W  optional feature only

Behaviour:
- Storage: main register (drives outputs) plus one skid register, each with its own valid bit. State is derived from the two valid bits.
- Handshakes: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- State EMPTY (no valid entries): in_fire -> main<=input, go to ONE.
- State ONE (main valid):
  - in_fire & out_fire -> main<=input, stay ONE.
  - in_fire & !out_fire -> skid<=input, go to FULL.
  - !in_fire & out_fire -> main valid cleared, go to EMPTY.
  - neither -> hold.
- State FULL (main and skid valid):
  - o_ready=0, so in_fire is impossible.
  - out_fire -> main<=skid, skid cleared, go to ONE.
  - otherwise hold.
- Latency: an entry accepted on edge N appears on the outputs after edge N (1 cycle) when the buffer is empty. Throughput is 1 entry/cycle when i_ready stays high.
- o_ready = !skid_valid, registered. No combinational path from i_ready to o_ready.
- Priority, evaluated each falling edge: rst > flush > enable=0 > normal operation.
- Reset:
  - All valids=0; o_ready=1.
  - o_WB, o_MemData, o_alu, o_Rdst and skid contents=0.
  - Counters=0.
- Flush:
  - Both valids=0; o_WB and skid WB=0, so the bubble cannot write.
  - Other data outputs hold their values.
  - An in_fire on the same edge is dropped. Flush acts even when enable=0.
- enable=0: no state change. Handshakes are ignored (in_fire and out_fire are treated as 0) and counters hold.
- Output data is stable while o_valid=1 & i_ready=0.
- Forwarding outputs are combinational from registered state only. fwd_valid=0 whenever o_valid=0.

Optional Feature:
MEM_WB_STATS_EN
- Defined:
  - stall_cnt increments on each enabled edge with o_valid & !i_ready.
  - bubble_cnt increments on each enabled edge with !o_valid.
  - Both saturate at 2^CNT_W-1, are cleared only by rst (not by flush), and hold when enable=0.
- Undefined: the stall_cnt and bubble_cnt ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with rst=1 for 2 edges -> o_valid=0, o_ready=1, all data outputs 0, fwd_valid=0.
- Streaming: i_ready=1; push WB=4'b0001, alu=16'h1234, Rdst=3 then WB=4'b0011, MemData=32'hDEADBEEF, Rdst=5 -> outputs follow one cycle later; fwd_data=16'h1234 then 16'hBEEF.
- Backpressure: i_ready=0 after first entry; push 3 entries A,B,C -> A held, B in skid, o_ready=0, C not accepted. Raise i_ready -> A, B, C emerge in order with no loss or duplication.
- Flush while FULL, with i_valid=1 on the same edge -> o_valid=0, o_WB=0, o_ready=1 next cycle; the entry offered on the flush edge never appears.
- enable=0 for 3 cycles with i_valid=1 and i_ready=1 -> no state change. Resume -> stream continues, nothing skipped.
- With MEM_WB_STATS_EN and CNT_W=4: hold i_ready=0 with a valid entry for 20 edges -> stall_cnt saturates at 15. A following flush leaves the counter at 15.

Source files
------------

// File: rtl/mem_wb_skid_buf.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush and a write-back
// forwarding tap. All state updates on the falling edge of clk.
// Optional: define MEM_WB_STATS_EN to add saturating stall/bubble counters.
module mem_wb_skid_buf #(
   parameter int WB_W        = 4,
   parameter int DATA_W      = 32,
   parameter int ALU_W       = 16,
   parameter int REG_W       = 3,
   parameter int WREN_BIT    = 0,
   parameter int MEM2REG_BIT = 1
`ifdef MEM_WB_STATS_EN
   ,parameter int CNT_W      = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WB_W-1:0]   i_WB,
   input  logic [DATA_W-1:0] i_MemData,
   input  logic [ALU_W-1:0]  i_alu,
   input  logic [REG_W-1:0]  i_Rdst,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [WB_W-1:0]   o_WB,
   output logic [DATA_W-1:0] o_MemData,
   output logic [ALU_W-1:0]  o_alu,
   output logic [REG_W-1:0]  o_Rdst,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_rdst,
   output logic [ALU_W-1:0]  fwd_data
`ifdef MEM_WB_STATS_EN
   ,output logic [CNT_W-1:0] stall_cnt
   ,output logic [CNT_W-1:0] bubble_cnt
`endif
);

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [DATA_W-1:0] mem;
      logic [ALU_W-1:0]  alu;
      logic [REG_W-1:0]  rdst;
   } pay_t;

   pay_t main_q, main_d, skid_q, skid_d, in_pay;
   logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic in_fire, out_fire;

   assign in_pay   = '{wb: i_WB, mem: i_MemData, alu: i_alu, rdst: i_Rdst};
   // Disabled cycles see no handshakes at all.
   assign in_fire  = enable & i_valid & ~skid_vld_q;
   assign out_fire = enable & main_vld_q & i_ready;

   // Next-state: EMPTY / ONE / FULL implied by the two valid bits; flush overrides.
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (out_fire) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (in_fire) begin
            main_d     = in_pay;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         if (main_vld_q) begin
            skid_d     = in_pay;
            skid_vld_d = 1'b1;
         end else begin
            main_d     = in_pay;
            main_vld_d = 1'b1;
         end
      end
      // Bubble: drop everything and zero WB so nothing can write back.
      if (flush) begin
         main_d     = main_q;
         skid_d     = skid_q;
         main_d.wb  = '0;
         skid_d.wb  = '0;
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end
   end

   // Buffer registers; reset clears payload too so outputs read 0.
   always_ff @(negedge clk) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign o_ready   = ~skid_vld_q;
   assign o_valid   = main_vld_q;
   assign o_WB      = main_q.wb;
   assign o_MemData = main_q.mem;
   assign o_alu     = main_q.alu;
   assign o_Rdst    = main_q.rdst;

   assign fwd_valid = main_vld_q & main_q.wb[WREN_BIT];
   assign fwd_rdst  = main_q.rdst;
   assign fwd_data  = main_q.wb[MEM2REG_BIT] ? main_q.mem[ALU_W-1:0] : main_q.alu;

`ifdef MEM_WB_STATS_EN
   logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

   // Saturating counters, advanced only on enabled edges; flush does not clear.
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (enable) begin
         if (main_vld_q && !i_ready && stall_q != '1) stall_d = stall_q + CNT_W'(1);
         if (!main_vld_q && bubble_q != '1)          bubble_d = bubble_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(negedge clk) begin
      if (rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_buf.sv
// Directed bench for mem_wb_skid_buf. Inputs change 1 time unit after each
// falling edge; outputs are checked at that same point.
module tb_mem_wb_skid_buf;
   localparam int WB_W = 4, DATA_W = 32, ALU_W = 16, REG_W = 3;
`ifdef MEM_WB_STATS_EN
   localparam int CNT_W = 4;
`endif

   logic clk = 1'b1;
   logic rst, enable, flush, i_valid, o_ready, o_valid, i_ready;
   logic [WB_W-1:0]   i_WB, o_WB;
   logic [DATA_W-1:0] i_MemData, o_MemData;
   logic [ALU_W-1:0]  i_alu, o_alu, fwd_data;
   logic [REG_W-1:0]  i_Rdst, o_Rdst, fwd_rdst;
   logic              fwd_valid;
`ifdef MEM_WB_STATS_EN
   logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_wb_skid_buf #(
      .WB_W(WB_W), .DATA_W(DATA_W), .ALU_W(ALU_W), .REG_W(REG_W),
      .WREN_BIT(0), .MEM2REG_BIT(1)
`ifdef MEM_WB_STATS_EN
      ,.CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_WB(i_WB), .i_MemData(i_MemData), .i_alu(i_alu), .i_Rdst(i_Rdst),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_WB(o_WB), .o_MemData(o_MemData), .o_alu(o_alu), .o_Rdst(o_Rdst),
      .fwd_valid(fwd_valid), .fwd_rdst(fwd_rdst), .fwd_data(fwd_data)
`ifdef MEM_WB_STATS_EN
      ,.stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [WB_W-1:0] wb, input logic [DATA_W-1:0] md,
                       input logic [ALU_W-1:0] alu, input logic [REG_W-1:0] rd);
      i_valid = 1'b1; i_WB = wb; i_MemData = md; i_alu = alu; i_Rdst = rd;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_WB = '0; i_MemData = '0; i_alu = '0; i_Rdst = '0;
      tick(); tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid got=%b exp=0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_o_ready got=%b exp=1", o_ready); end
      total++; if (o_WB !== 4'h0) begin bad++; $display("FAIL rst_o_WB got=%h exp=0", o_WB); end
      total++; if (o_MemData !== 32'h0) begin bad++; $display("FAIL rst_o_MemData got=%h exp=0", o_MemData); end
      total++; if (o_alu !== 16'h0) begin bad++; $display("FAIL rst_o_alu got=%h exp=0", o_alu); end
      total++; if (o_Rdst !== 3'h0) begin bad++; $display("FAIL rst_o_Rdst got=%h exp=0", o_Rdst); end
      total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL rst_fwd_valid got=%b exp=0", fwd_valid); end
`ifdef MEM_WB_STATS_EN
      total++; if (stall_cnt !== 4'h0) begin bad++; $display("FAIL rst_stall_cnt got=%h exp=0", stall_cnt); end
      total++; if (bubble_cnt !== 4'h0) begin bad++; $display("FAIL rst_bubble_cnt got=%h exp=0", bubble_cnt); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_stream();
      i_ready = 1'b1;
      push(4'b0001, 32'h0, 16'h1234, 3'd3);
      tick();
      total++; if (o_valid !== 1'b1 || o_alu !== 16'h1234 || o_Rdst !== 3'd3 || o_WB !== 4'b0001)
         begin bad++; $display("FAIL stream_e1 got v=%b alu=%h rd=%0d wb=%h exp v=1 alu=1234 rd=3 wb=1", o_valid, o_alu, o_Rdst, o_WB); end
      total++; if (fwd_valid !== 1'b1 || fwd_data !== 16'h1234 || fwd_rdst !== 3'd3)
         begin bad++; $display("FAIL stream_fwd1 got v=%b d=%h rd=%0d exp v=1 d=1234 rd=3", fwd_valid, fwd_data, fwd_rdst); end
      push(4'b0011, 32'hDEADBEEF, 16'h5555, 3'd5);
      tick();
      total++; if (o_WB !== 4'b0011 || o_MemData !== 32'hDEADBEEF || o_Rdst !== 3'd5 || o_ready !== 1'b1)
         begin bad++; $display("FAIL stream_e2 got wb=%h md=%h rd=%0d rdy=%b exp wb=3 md=deadbeef rd=5 rdy=1", o_WB, o_MemData, o_Rdst, o_ready); end
      total++; if (fwd_valid !== 1'b1 || fwd_data !== 16'hBEEF)
         begin bad++; $display("FAIL stream_fwd2 got v=%b d=%h exp v=1 d=beef", fwd_valid, fwd_data); end
      // memory-select set but write enable clear: valid entry, no forward
      push(4'b0010, 32'hCAFEF00D, 16'h7777, 3'd6);
      tick();
      total++; if (o_valid !== 1'b1 || fwd_valid !== 1'b0 || fwd_data !== 16'hF00D)
         begin bad++; $display("FAIL stream_nowr got v=%b fv=%b d=%h exp v=1 fv=0 d=f00d", o_valid, fwd_valid, fwd_data); end
      i_valid = 1'b0;
      tick();
      total++; if (o_valid !== 1'b0 || fwd_valid !== 1'b0)
         begin bad++; $display("FAIL stream_drain got v=%b fv=%b exp 0 0", o_valid, fwd_valid); end
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0;
      push(4'b0001, 32'h0, 16'h00A1, 3'd1);
      tick();
      push(4'b0001, 32'h0, 16'h00B2, 3'd2);
      tick();
      total++; if (o_alu !== 16'h00A1 || o_ready !== 1'b0 || o_valid !== 1'b1)
         begin bad++; $display("FAIL bp_full got alu=%h rdy=%b v=%b exp alu=00a1 rdy=0 v=1", o_alu, o_ready, o_valid); end
      push(4'b0001, 32'h0, 16'h00C3, 3'd3);
      tick();
      total++; if (o_alu !== 16'h00A1 || o_Rdst !== 3'd1 || o_ready !== 1'b0)
         begin bad++; $display("FAIL bp_hold got alu=%h rd=%0d rdy=%b exp alu=00a1 rd=1 rdy=0", o_alu, o_Rdst, o_ready); end
      i_ready = 1'b1;
      tick();
      total++; if (o_alu !== 16'h00B2 || o_valid !== 1'b1 || o_ready !== 1'b1)
         begin bad++; $display("FAIL bp_B got alu=%h v=%b rdy=%b exp alu=00b2 v=1 rdy=1", o_alu, o_valid, o_ready); end
      tick();
      total++; if (o_alu !== 16'h00C3 || o_Rdst !== 3'd3 || o_valid !== 1'b1)
         begin bad++; $display("FAIL bp_C got alu=%h rd=%0d v=%b exp alu=00c3 rd=3 v=1", o_alu, o_Rdst, o_valid); end
      i_valid = 1'b0;
      tick();
      total++; if (o_valid !== 1'b0)
         begin bad++; $display("FAIL bp_empty got v=%b exp 0", o_valid); end
   endtask

   task automatic test_flush();
      i_ready = 1'b0;
      push(4'b0001, 32'h0, 16'h00D4, 3'd4);
      tick();
      push(4'b0001, 32'h0, 16'h00E5, 3'd5);
      tick();
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL fl_pre got rdy=%b exp 0", o_ready); end
      push(4'b0011, 32'h0, 16'h00F6, 3'd6);
      flush = 1'b1;
      tick();
      total++; if (o_valid !== 1'b0 || o_WB !== 4'h0 || o_ready !== 1'b1 || fwd_valid !== 1'b0)
         begin bad++; $display("FAIL fl_bubble got v=%b wb=%h rdy=%b fv=%b exp v=0 wb=0 rdy=1 fv=0", o_valid, o_WB, o_ready, fwd_valid); end
      total++; if (o_alu !== 16'h00D4 || o_Rdst !== 3'd4)
         begin bad++; $display("FAIL fl_datahold got alu=%h rd=%0d exp alu=00d4 rd=4", o_alu, o_Rdst); end
      flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      tick();
      total++; if (o_valid !== 1'b0 || o_alu !== 16'h00D4)
         begin bad++; $display("FAIL fl_after got v=%b alu=%h exp v=0 alu=00d4", o_valid, o_alu); end
   endtask

   task automatic test_enable();
      i_ready = 1'b1;
      push(4'b0001, 32'h0, 16'h0107, 3'd7);
      tick();
      enable = 1'b0;
      push(4'b0001, 32'h0, 16'h0208, 3'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (o_alu !== 16'h0107 || o_valid !== 1'b1 || o_ready !== 1'b1)
            begin bad++; $display("FAIL en_frozen%0d got alu=%h v=%b rdy=%b exp alu=0107 v=1 rdy=1", k, o_alu, o_valid, o_ready); end
      end
      enable = 1'b1;
      tick();
      total++; if (o_alu !== 16'h0208 || o_Rdst !== 3'd0 || o_valid !== 1'b1)
         begin bad++; $display("FAIL en_resume got alu=%h rd=%0d v=%b exp alu=0208 rd=0 v=1", o_alu, o_Rdst, o_valid); end
      push(4'b0001, 32'h0, 16'h0309, 3'd1);
      tick();
      total++; if (o_alu !== 16'h0309) begin bad++; $display("FAIL en_next got alu=%h exp 0309", o_alu); end
      i_valid = 1'b0;
      tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL en_drain got v=%b exp 0", o_valid); end
   endtask

`ifdef MEM_WB_STATS_EN
   task automatic test_stats();
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
      tick();
      rst = 1'b0;
      push(4'b0001, 32'h0, 16'h0ABC, 3'd2);
      tick();   // o_valid was 0 on this edge: one bubble
      i_valid = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL st_sat got=%h exp=f", stall_cnt); end
      total++; if (bubble_cnt !== 4'h1) begin bad++; $display("FAIL st_bub1 got=%h exp=1", bubble_cnt); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL st_flush got=%h exp=f", stall_cnt); end
      tick();
      total++; if (bubble_cnt !== 4'h2) begin bad++; $display("FAIL st_bub2 got=%h exp=2", bubble_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_enable();
`ifdef MEM_WB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
